// File: rtl/tile_addr_gen.sv
// tile_addr_gen: walks a CHS x ROWS x COLS tile in row-major order, one buffer address per enabled cycle.
// Optional macro TILE_ADDR_PITCH_EN: rows advance by ROW_PITCH instead of COLS (padded buffer rows).
module tile_addr_gen #(
   parameter int unsigned AW        = 16,
   parameter int unsigned COLS      = 8,
   parameter int unsigned ROWS      = 4,
   parameter int unsigned CHS       = 2,
   parameter int unsigned ROW_PITCH = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          ena,
   input  logic [AW-1:0] base_addr,
   output logic [AW-1:0] addr,
   output logic          addr_vld,
   output logic          busy,
   output logic          done
);
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned KW = (CHS  > 1) ? $clog2(CHS)  : 1;
   localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
   localparam logic [KW-1:0] K_LAST = KW'(CHS - 1);
`ifdef TILE_ADDR_PITCH_EN
   localparam logic [AW-1:0] PITCH = AW'(ROW_PITCH);
`else
   // Dense rows: ROW_PITCH multiplies out to zero and adds no hardware.
   localparam logic [AW-1:0] PITCH = AW'(COLS + ROW_PITCH * 0);
`endif

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] c;
   logic [RW-1:0] r;
   logic [KW-1:0] k;
   logic [AW-1:0] row_base;
   logic [AW-1:0] cur_addr;

   // Channel stride is never computed: it is ROWS successive row advances.
   assign cur_addr = row_base + AW'(c);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         c        <= '0;
         r        <= '0;
         k        <= '0;
         row_base <= '0;
         addr     <= '0;
         addr_vld <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         addr_vld <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  row_base <= base_addr;
                  c        <= '0;
                  r        <= '0;
                  k        <= '0;
               end
            end
            RUN: begin
               if (ena) begin
                  addr     <= cur_addr;
                  addr_vld <= 1'b1;
                  if (c == C_LAST) begin
                     c        <= '0;
                     row_base <= row_base + PITCH;
                     if (r == R_LAST) begin
                        r <= '0;
                        if (k == K_LAST) begin
                           k     <= '0;
                           state <= DONE;
                        end else begin
                           k <= k + 1'b1;
                        end
                     end else begin
                        r <= r + 1'b1;
                     end
                  end else begin
                     c <= c + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/tile_addr_gen.md
# tile_addr_gen

Nested-loop address generator that walks a 3-D tile (channel, row, column) of an on-chip feature-map buffer in row-major order. It emits one linear buffer address per enabled cycle, followed by a one-cycle completion pulse. It sits directly upstream of the buffer read port. It reuses the start/ena/done control style of the loop counters so the tile controller can chain it with them.

## Interface
- AW, 16: address width.
- COLS, 8: inner-loop extent (columns), ≥1.
- ROWS, 4: middle-loop extent (rows), ≥1.
- CHS, 2: outer-loop extent (channels), ≥1.
- ROW_PITCH, 8: buffer words per row. Used only with TILE_ADDR_PITCH_EN; must be ≥COLS.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a tile walk. Sampled only in IDLE.
- ena  in  1  advance enable / downstream ready. When low, the walk holds.
- base_addr  in  AW  tile base address, latched on accepted start.
- addr  out  AW  current buffer address, registered.
- addr_vld  out  1  addr is valid this cycle, registered.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last address.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1. Latches base_addr, clears c/r/k indices and the running row base.
  - RUN→DONE on the posedge that issues the last element (c=COLS-1, r=ROWS-1, k=CHS-1, ena=1).
  - DONE→IDLE unconditionally after one cycle.
- In RUN, on each posedge with ena=1:
  - addr ← cur_addr, addr_vld ← 1.
  - c increments. On wrap c→0, r increments. On wrap r→0, k increments.
- In RUN with ena=0: addr_vld ← 0. Indices, cur_addr and addr hold. No address is skipped or repeated.
- Address arithmetic is incremental, with no multipliers:
  - cur_addr = row_base + c.
  - On c wrap, row_base += PITCH, where PITCH = ROW_PITCH with the macro, COLS without.
  - Channel stride is ROWS·PITCH and falls out of successive row advances.
  - All sums wrap modulo 2^AW.
- Total addresses per walk N = COLS·ROWS·CHS, each issued exactly once, in order.
- start while busy=1 is ignored; a pending start is not queued.
- start=1 in the DONE cycle is ignored. start in IDLE on the cycle right after DONE is accepted.

## Timing
- Reset values: addr=0, addr_vld=0, busy=0, done=0, state=IDLE, indices=0. Reset takes effect immediately, including mid-walk, and the walk is abandoned.
- Cycle numbering: start sampled at posedge t0, so busy=1 from t0.
- Earliest first address: ena=1 at posedge t0+1 gives addr_vld=1 in the cycle after t0+1.
- With ena held high:
  - addresses appear on N consecutive cycles;
  - done=1 exactly one cycle after the last addr_vld cycle, with addr_vld=0 then;
  - busy falls together with done.
- ena deasserted during DONE does not delay done.
- Degenerate COLS=ROWS=CHS=1: one address, then done on the next cycle.

## Configuration
- TILE_ADDR_PITCH_EN defined: the row step is ROW_PITCH, which supports padded/strided buffer rows.
- TILE_ADDR_PITCH_EN undefined: the row step is COLS (dense tile). The ROW_PITCH parameter is unused and no extra adder operand is built.

## Test plan
- Dense walk (no macro), COLS=4, ROWS=3, CHS=2, base 0x0100, ena=1 → addresses 0x0100..0x0117 on 24 consecutive cycles, then done for 1 cycle, busy low after.
- Pitched walk (macro on, ROW_PITCH=8), same dims, base 0x0100 → k0: 0x100–0x103, 0x108–0x10B, 0x110–0x113; k1: 0x118–0x11B, 0x120–0x123, 0x128–0x12B; then done.
- Stall: ena low for 2 cycles after the 5th address and for 1 cycle on the last element → 24 valid addresses, no gaps or duplicates; done delayed by exactly 3 cycles.
- start pulsed at the 10th address and again during DONE → ignored, walk unchanged. start on the next IDLE cycle → new walk begins from the new base.
- rst low during the 7th address → addr_vld=0, busy=0 immediately. After release with start and base 0x0200 → addresses begin at 0x0200.
- Wrap: AW=8, base 0xFE, COLS=4, ROWS=1, CHS=1 → 0xFE, 0xFF, 0x00, 0x01, then done.
